// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment bit order is a..g on [0]..[6], active-high.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return (NUM_DIGITS)'(1) << idx;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed four-digit display driver with a double-buffered value so that
// a new value only ever replaces the old one at a frame boundary.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic [15:0] value_i,
  input  logic        value_valid_i,
  output logic        value_ready_o,
  input  logic        blank_lz_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  digit_en_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescale;
  logic [1:0]       idx;
  logic             tick;
  digits_t          shadow;
  digits_t          display;
  logic             pending;
  logic             accept;
  logic             transfer;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic             blank_cur;

  assign tick          = active && (prescale == CNT_LAST);
  assign value_ready_o = !pending && !wb_rst_i;
  assign accept        = value_valid_i && value_ready_o;
  // Going inactive flushes any waiting value straight into the display.
  assign transfer      = pending && (!active || (tick && idx == 2'd3));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !active) begin
      prescale <= '0;
      idx      <= '0;
    end else if (tick) begin
      prescale <= '0;
      idx      <= idx + 2'd1;
    end else begin
      prescale <= prescale + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (transfer)
        display <= shadow;
      if (accept)
        shadow <= value_i;
      if (accept)
        pending <= 1'b1;
      else if (transfer)
        pending <= 1'b0;
    end
  end

  assign cur_digit = display[idx];

  seven_seg_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // A digit is a leading zero when it and every more significant digit is 0.
  always_comb begin
    blank_cur = 1'b0;
    if (blank_lz_i && idx != 2'd0) begin
      blank_cur = 1'b1;
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (n >= int'(idx) && display[n] != 4'd0)
          blank_cur = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !active) begin
      seg_o      <= SEG_BLANK;
      digit_en_o <= '0;
    end else begin
      seg_o      <= blank_cur ? SEG_BLANK : dec_seg;
      digit_en_o <= digit_onehot(idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a timing model built from slot arithmetic.
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        act = 1'b0;
  logic        valid = 1'b0;
  logic        blz = 1'b0;
  logic [15:0] val = '0;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  en;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // model state: m_t counts active cycles since scanning (re)started
  int          m_t = 0;
  bit          m_pend = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp = '0;
  logic [6:0]  m_seg = '0;
  logic [3:0]  m_en = '0;
  bit          m_known = 0;
  bit          cur_rst = 1;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .active        (act),
    .value_i       (val),
    .value_valid_i (valid),
    .value_ready_o (ready),
    .blank_lz_i    (blz),
    .seg_o         (seg),
    .digit_en_o    (en)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_idx();
    return (m_t / DIV) % 4;
  endfunction

  function automatic logic [6:0] model_seg(input int n, input bit b);
    logic [15:0] upper;
    upper = m_disp >> (4 * n);
    if (b && n != 0 && upper == 16'h0)
      return 7'h00;
    return seg_tab[(m_disp >> (4 * n)) & 16'hF];
  endfunction

  task automatic cycle(input bit r, input bit a, input bit v, input logic [15:0] d, input bit b);
    int  idx;
    bit  tick, xfer, acc;
    @(negedge clk);
    if (m_known) begin
      check("seg", 16'(seg), 16'(m_seg));
      check("digit_en", 16'(en), 16'(m_en));
      check("ready", 16'(ready), 16'(!m_pend && !cur_rst));
    end
    rst = r; act = a; valid = v; val = d; blz = b;
    cur_rst = r;
    if (r) begin
      m_t = 0; m_pend = 0; m_shadow = '0; m_disp = '0; m_seg = '0; m_en = '0;
      m_known = 1;
    end else begin
      idx  = model_idx();
      tick = a && (m_t % DIV == DIV - 1);
      if (a) begin
        m_en  = 4'(1 << idx);
        m_seg = model_seg(idx, b);
      end else begin
        m_en = '0; m_seg = '0;
      end
      xfer = m_pend && (!a || (tick && idx == 3));
      acc  = v && !m_pend;
      if (xfer) m_disp = m_shadow;
      if (acc) m_shadow = d;
      if (acc) m_pend = 1;
      else if (xfer) m_pend = 0;
      m_t = a ? m_t + 1 : 0;
    end
  endtask

  task automatic idle(input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) cycle(0, a, 0, 16'h0, b);
  endtask

  task automatic load(input logic [15:0] d, input bit b);
    cycle(0, 1, 1, d, b);
  endtask

  // bounded wait for a digit select, then compare the segment pattern
  task automatic expect_digit(input string tag, input logic [3:0] sel, input logic [6:0] exp_seg);
    int i;
    i = 0;
    while (en !== sel && i < 40) begin
      idle(1, 1, blz);
      i++;
    end
    check({tag, "_en"}, 16'(en), 16'(sel));
    check(tag, 16'(seg), 16'(exp_seg));
  endtask

  initial begin
    repeat (3) cycle(1, 0, 0, 16'h0, 0);
    idle(20, 1, 0);
    expect_digit("zero_d3", 4'b1000, 7'h3F);

    while (model_idx() != 1) idle(1, 1, 0);
    load(16'h1234, 0);
    idle(2, 1, 0);
    load(16'h9999, 0);
    idle(24, 1, 0);
    expect_digit("v1234_d0", 4'b0001, 7'h66);
    expect_digit("v1234_d1", 4'b0010, 7'h4F);
    expect_digit("v1234_d2", 4'b0100, 7'h5B);
    expect_digit("v1234_d3", 4'b1000, 7'h06);

    load(16'h0050, 1);
    idle(36, 1, 1);
    expect_digit("lz_d3", 4'b1000, 7'h00);
    expect_digit("lz_d1", 4'b0010, 7'h6D);
    idle(20, 1, 0);
    expect_digit("nolz_d3", 4'b1000, 7'h3F);

    load(16'h00AF, 0);
    idle(36, 1, 0);
    expect_digit("hex_d0", 4'b0001, 7'h40);

    load(16'h4321, 0);
    idle(2, 1, 0);
    idle(5, 0, 0);
    idle(24, 1, 0);

    load(16'h7777, 0);
    idle(1, 1, 0);
    cycle(1, 1, 0, 16'h0, 0);
    cycle(1, 1, 0, 16'h0, 0);
    idle(20, 1, 0);
    expect_digit("rst_d2", 4'b0100, 7'h3F);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
          {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 31) != 0,
            $urandom_range(0, 7) == 0, d, $urandom_range(0, 1) == 1);
    end
    idle(2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
